tx_sched: RTL
=============

Name: tx_sched

Overview:
- Frame scheduler in front of the DCSK transmitter.
- Queues message requests ({32-bit msg, spreading factor}) from upstream in a small FIFO.
- Drives the transmitter's seed-load, send, msg and sf controls one frame at a time. It watches the transmitter's is_sending flag for start and completion.
- Enforces a programmable inter-frame gap and flags a frame that never starts.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SF_W, 3, width of the spreading-factor code (spreading_factors_pkg encoding).
- GAP_W, 8, width of the inter-frame gap count.
- TO_CYC, 16, cycles allowed from the send pulse to is_sending rising before a timeout.

Ports:
- i_clk  in  1  system clock
- i_arst_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream request valid
- o_ready  out  1  FIFO can accept; equals ~full
- i_msg  in  32  message to send
- i_sf  in  SF_W  spreading factor for this message
- i_gap  in  GAP_W  idle cycles between frames; sampled at frame completion
- i_seed  in  8  chaotic-generator seed
- o_tx_seed  out  8  to tx i_seed
- o_tx_load_seed  out  1  to tx i_load_seed; one-cycle pulse
- o_tx_send  out  1  to tx i_send; one-cycle pulse
- o_tx_msg  out  32  to tx i_msg; held stable from the send pulse until frame done
- o_tx_sf  out  SF_W  to tx i_sf; held as o_tx_msg
- i_is_sending  in  1  from tx is_sending
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle pulse on frame completion
- o_timeout  out  1  one-cycle pulse when a frame fails to start
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0, o_ready=1, FIFO emptied, FSM=IDLE. Reset asserted mid-frame aborts the frame with no o_done.
- Push: accepted when i_valid & o_ready. o_ready does not depend on a same-cycle pop, so a full FIFO refuses input.
- Pop: occurs on the IDLE->SEND transition only. Push and pop in the same cycle leave o_level unchanged.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head into the o_tx_msg/o_tx_sf registers and go to SEND.
  - SEND: o_tx_send=1 for exactly one cycle, then go to WAIT_START.
  - WAIT_START: count cycles.
    - If i_is_sending=1, go to BUSY.
    - Otherwise, after TO_CYC cycles pulse o_timeout, drop the frame, and go to GAP.
  - BUSY: on i_is_sending=0 (first cycle low), pulse o_done, load the gap counter with i_gap, and go to GAP.
  - GAP: decrement each cycle; go to IDLE when the counter is 0. With i_gap=0, GAP lasts 1 cycle.
- Latency: a push into an empty idle FIFO gives o_tx_send two cycles after the push edge (one cycle FIFO write, one cycle IDLE->SEND).
- o_tx_seed mirrors i_seed, registered.
- Pointers wrap modulo DEPTH. o_level spans 0..DEPTH.
- A rise of i_is_sending outside WAIT_START is ignored; no state change.

Optional Feature:
- Macro: TX_SCHED_RESEED_EN.
- Defined: a LOAD state sits between IDLE and SEND. It drives o_tx_load_seed=1 for one cycle with o_tx_seed=i_seed, so every frame starts from a known chaotic state. Push-to-send latency becomes 3 cycles.
- Undefined: no LOAD state, and o_tx_load_seed is tied to 0. Seeding is then done externally.

Test Plan:
- Reset, then push {32'hFACEB00C, SF16} with i_gap=4. Expect:
  - o_tx_send pulses once, 2 cycles after the push (3 with RESEED).
  - o_tx_msg=32'hFACEB00C is held through BUSY.
  - o_done pulses once is_sending falls.
  - IDLE is re-entered 4 cycles later.
- Push 32'hFACEB00C then 32'h66DEAD66 back-to-back. Expect two frames in order, with the second o_tx_send exactly i_gap+2 cycles after the first o_done.
- Push DEPTH+1 entries with the transmitter stalled. Expect:
  - o_ready=0 after DEPTH accepted.
  - The extra push is refused.
  - o_level=DEPTH.
- Hold i_is_sending=0 after a send. Expect:
  - o_timeout pulses TO_CYC cycles after o_tx_send.
  - No o_done.
  - The next queued message is sent afterwards.
- Assert i_arst_n=0 during BUSY with 2 entries queued. Expect:
  - All outputs 0 and o_level=0.
  - After release, no spurious o_tx_send.
- With TX_SCHED_RESEED_EN and i_seed=8'h15, send two frames. Expect o_tx_load_seed to pulse with o_tx_seed=8'h15 one cycle before each o_tx_send.

Source files
------------

// File: rtl/tx_sched.sv
// Frame scheduler feeding the DCSK transmitter: request FIFO, send/complete FSM, gap and start timeout.
// Optional TX_SCHED_RESEED_EN adds a seed-load cycle ahead of every send.
module tx_sched #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SF_W   = 3,
  parameter int unsigned GAP_W  = 8,
  parameter int unsigned TO_CYC = 16
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_msg,
  input  logic [SF_W-1:0]          i_sf,
  input  logic [GAP_W-1:0]         i_gap,
  input  logic [7:0]               i_seed,
  output logic [7:0]               o_tx_seed,
  output logic                     o_tx_load_seed,
  output logic                     o_tx_send,
  output logic [31:0]              o_tx_msg,
  output logic [SF_W-1:0]          o_tx_sf,
  input  logic                     i_is_sending,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TO_CYC + 1);

  typedef struct packed {
    logic [31:0]     msg;
    logic [SF_W-1:0] sf;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_BUSY,
    S_GAP
  } state_t;

  state_t            state;
  req_t              mem [DEPTH];
  req_t              head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic [LW-1:0]     count_nxt;
  logic              push;
  logic              pop;
  logic [TW-1:0]     to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // o_ready is a register, so a same-cycle pop never makes room for a push
  assign push    = i_valid & o_ready;
  assign pop     = (state == S_IDLE) && (count != '0);
  assign head    = mem[rd_ptr];
  assign o_level = count;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + LW'(1);
    end else if (pop && !push) begin
      count_nxt = count - LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= req_t'{msg: i_msg, sf: i_sf};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      o_ready <= (count_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_tx_seed <= '0;
    end else begin
      o_tx_seed <= i_seed;
    end
  end

`ifndef TX_SCHED_RESEED_EN
  assign o_tx_load_seed = 1'b0;
`endif

  // Frame FSM; pulse outputs default low every cycle
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      o_tx_send <= 1'b0;
      o_tx_msg  <= '0;
      o_tx_sf   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
`ifdef TX_SCHED_RESEED_EN
      o_tx_load_seed <= 1'b0;
`endif
    end else begin
      o_tx_send <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
`ifdef TX_SCHED_RESEED_EN
      o_tx_load_seed <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            o_tx_msg <= head.msg;
            o_tx_sf  <= head.sf;
            o_busy   <= 1'b1;
`ifdef TX_SCHED_RESEED_EN
            state    <= S_LOAD;
`else
            state    <= S_SEND;
`endif
          end
        end
`ifdef TX_SCHED_RESEED_EN
        S_LOAD: begin
          o_tx_load_seed <= 1'b1;
          state          <= S_SEND;
        end
`endif
        S_SEND: begin
          o_tx_send <= 1'b1;
          to_cnt    <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_is_sending) begin
            state <= S_BUSY;
          end else if (to_cnt == TW'(TO_CYC - 1)) begin
            o_timeout <= 1'b1;
            gap_cnt   <= i_gap;
            state     <= S_GAP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_BUSY: begin
          if (!i_is_sending) begin
            o_done  <= 1'b1;
            gap_cnt <= i_gap;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          // a gap of 0 or 1 both return to IDLE on the first GAP cycle
          if (gap_cnt <= GAP_W'(1)) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
